microstore_sequencer: RTL and testbench
=======================================

// Module: microstore_sequencer
// PURPOSE
//  Next-state sequencer for the microprogrammed ARM control unit. Each cycle it selects the next control-store
//  state from one of five sources: the instruction encoder's decoded state, the current state + 1, a branch
//  target, the fetch state, or a one-entry return register. It stalls while a memory operation is pending
//  (MOC handshake) and drives the state number that addresses the control-store ROM.
// PARAMETERS
//  SW           8     state number width (matches encoder output width)
//  RESET_STATE  0     state loaded on reset
//  FETCH_STATE  1     target of NS_FETCH
//  UNDEF_STATE  2     target of NS_DECODE when enc_valid=0 (undefined instruction)
//  FAULT_STATE  255   target on sequencing fault
//  MOC_TIMEOUT  15    max stall cycles before fault (only with MOC_TIMEOUT_EN)
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    synchronous, active-high
//  ns_sel     in   3    next-state select from current microinstruction (encodings in package)
//  cr_addr    in   SW   branch/call target field of microinstruction
//  inv        in   1    invert condition for NS_COND
//  cond_true  in   1    condition tester result
//  enc_state  in   SW   decoded state from instruction encoder
//  enc_valid  in   1    encoder recognised the IR
//  mem_op     in   1    current microinstruction starts/continues a memory operation
//  moc        in   1    memory operation complete
//  state      out  SW   current control-store state
//  stall      out  1    = mem_op & ~moc (combinational)
//  fault      out  1    sticky fault flag
// BEHAVIOUR
//  - Reset (sync, high): state<=RESET_STATE, ret_valid<=0, ret_addr<=0, fault<=0, timeout counter<=0.
//    Reset dominates every other input in the same cycle.
//  - state is registered; one-cycle latency from ns_sel/cr_addr to the new state.
//  - Stall: when mem_op=1 and moc=0, state, ret_* and fault hold. The transition is taken in the first
//    cycle with moc=1. moc is ignored when mem_op=0.
//  - Next-state select (inc = state+1 mod 2^SW, so 255 wraps to 0):
//     NS_DECODE 000: enc_valid ? enc_state : UNDEF_STATE
//     NS_INC    001: inc
//     NS_JUMP   010: cr_addr
//     NS_COND   011: (cond_true^inv) ? cr_addr : inc
//     NS_FETCH  100: FETCH_STATE
//     NS_CALL   110: if !ret_valid: ret_addr<=inc, ret_valid<=1, state<=cr_addr; else fault
//     NS_RETURN 101: if ret_valid: state<=ret_addr, ret_valid<=0; else fault
//     111 reserved: fault
//  - On fault: state<=FAULT_STATE, fault<=1 (cleared only by reset), ret_valid unchanged. While fault=1
//    the sequencer continues to obey ns_sel, so the fault microroutine can run.
// CONFIGURATION
//  MOC_TIMEOUT_EN defined: a counter increments each stall cycle and clears on any non-stall cycle.
//    When a stall cycle occurs with counter==MOC_TIMEOUT-1, the next state is FAULT_STATE, fault<=1,
//    and the counter clears (the MOC_TIMEOUT-th consecutive stall cycle faults).
//  MOC_TIMEOUT_EN undefined: no counter; stalls last indefinitely; faults arise only from call/return/
//    reserved-select errors.
// STRUCTURE
//  - Package microstore_pkg: NS_* localparams (3-bit), default RESET/FETCH/UNDEF/FAULT state constants.
//  - One sub-module, microstore_next_mux: combinational next-state and fault computation from the
//    select inputs, current state and return register. The top level holds the state, return register,
//    fault flag and timeout counter.
// TESTING
//  1 Reset, then ns_sel=INC for 3 cycles -> state 0,1,2,3; hold state=255 with INC -> next state 0.
//  2 ns_sel=DECODE, enc_valid=1, enc_state=16 -> state=16; enc_valid=0 -> state=2 (UNDEF).
//  3 COND with cr_addr=40 at state 10: cond_true=1,inv=0 -> 40; cond_true=1,inv=1 -> 11.
//  4 CALL cr_addr=50 at state 20 -> 50; RETURN -> 21; second RETURN -> state 255, fault=1.
//  5 mem_op=1, moc=0 for 4 cycles with ns_sel=JUMP 60 -> state holds, stall=1; moc=1 -> state=60.
//  6 MOC_TIMEOUT_EN: mem_op=1, moc never set -> state=255 and fault=1 after the 15th stall cycle;
//    reset asserted in the middle of a stall -> state=0, fault=0 on the next cycle.

Source files
------------

// File: rtl/microstore_sequencer_pkg.sv
// Shared constants for the microstore sequencer: next-state select encodings
// and the default control-store state numbers.
package microstore_pkg;

    typedef logic [2:0] ns_sel_t;

    localparam ns_sel_t NS_DECODE = 3'b000;
    localparam ns_sel_t NS_INC    = 3'b001;
    localparam ns_sel_t NS_JUMP   = 3'b010;
    localparam ns_sel_t NS_COND   = 3'b011;
    localparam ns_sel_t NS_FETCH  = 3'b100;
    localparam ns_sel_t NS_RETURN = 3'b101;
    localparam ns_sel_t NS_CALL   = 3'b110;
    localparam ns_sel_t NS_RSVD   = 3'b111;

    localparam int unsigned DEF_SW          = 8;
    localparam int unsigned DEF_RESET_STATE = 0;
    localparam int unsigned DEF_FETCH_STATE = 1;
    localparam int unsigned DEF_UNDEF_STATE = 2;
    localparam int unsigned DEF_FAULT_STATE = 255;
    localparam int unsigned DEF_MOC_TIMEOUT = 15;

endpackage

// File: rtl/microstore_sequencer_if.sv
// Bus between the current microinstruction fields / condition logic and the
// microstore sequencer. The master drives the microinstruction side, the
// slave (sequencer) drives the control-store state and status.
interface microstore_sequencer_if #(
    parameter int unsigned SW = 8
);
    logic [2:0]    ns_sel;
    logic [SW-1:0] cr_addr;
    logic          inv;
    logic          cond_true;
    logic [SW-1:0] enc_state;
    logic          enc_valid;
    logic          mem_op;
    logic          moc;
    logic [SW-1:0] state;
    logic          stall;
    logic          fault;

    modport master (
        output ns_sel, cr_addr, inv, cond_true, enc_state, enc_valid, mem_op, moc,
        input  state, stall, fault
    );

    modport slave (
        input  ns_sel, cr_addr, inv, cond_true, enc_state, enc_valid, mem_op, moc,
        output state, stall, fault
    );
endinterface

// File: rtl/microstore_sequencer_next_mux.sv
// Combinational next-state selection for the microstore sequencer. Produces the
// candidate next state, the updated return register and a fault event for
// call/return misuse or the reserved select code.
module microstore_next_mux
    import microstore_pkg::*;
#(
    parameter int unsigned SW          = DEF_SW,
    parameter int unsigned FETCH_STATE = DEF_FETCH_STATE,
    parameter int unsigned UNDEF_STATE = DEF_UNDEF_STATE,
    parameter int unsigned FAULT_STATE = DEF_FAULT_STATE
) (
    input  logic [2:0]    i_ns_sel,
    input  logic [SW-1:0] i_cr_addr,
    input  logic          i_inv,
    input  logic          i_cond_true,
    input  logic [SW-1:0] i_enc_state,
    input  logic          i_enc_valid,
    input  logic [SW-1:0] i_state,
    input  logic          i_ret_valid,
    input  logic [SW-1:0] i_ret_addr,
    output logic [SW-1:0] o_next_state,
    output logic          o_next_ret_valid,
    output logic [SW-1:0] o_next_ret_addr,
    output logic          o_fault
);
    localparam logic [SW-1:0] L_FETCH = SW'(FETCH_STATE);
    localparam logic [SW-1:0] L_UNDEF = SW'(UNDEF_STATE);
    localparam logic [SW-1:0] L_FAULT = SW'(FAULT_STATE);

    logic [SW-1:0] w_inc;

    // Increment wraps naturally at 2^SW
    assign w_inc = i_state + SW'(1);

    // Select next state; a fault overrides the target but leaves the return register alone
    always_comb begin
        o_next_state     = w_inc;
        o_next_ret_valid = i_ret_valid;
        o_next_ret_addr  = i_ret_addr;
        o_fault          = 1'b0;
        unique case (i_ns_sel)
            NS_DECODE: o_next_state = i_enc_valid ? i_enc_state : L_UNDEF;
            NS_INC:    o_next_state = w_inc;
            NS_JUMP:   o_next_state = i_cr_addr;
            NS_COND:   o_next_state = (i_cond_true ^ i_inv) ? i_cr_addr : w_inc;
            NS_FETCH:  o_next_state = L_FETCH;
            NS_CALL: begin
                if (!i_ret_valid) begin
                    o_next_state     = i_cr_addr;
                    o_next_ret_valid = 1'b1;
                    o_next_ret_addr  = w_inc;
                end else begin
                    o_next_state = L_FAULT;
                    o_fault      = 1'b1;
                end
            end
            NS_RETURN: begin
                if (i_ret_valid) begin
                    o_next_state     = i_ret_addr;
                    o_next_ret_valid = 1'b0;
                end else begin
                    o_next_state = L_FAULT;
                    o_fault      = 1'b1;
                end
            end
            default: begin
                o_next_state = L_FAULT;
                o_fault      = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/microstore_sequencer.sv
// Microstore next-state sequencer for the microprogrammed control unit.
// Holds the control-store state, the one-entry return register and the sticky
// fault flag, and stalls while a memory operation awaits MOC.
// Optional feature: define MOC_TIMEOUT_EN to fault after MOC_TIMEOUT
// consecutive stall cycles.
module microstore_sequencer
    import microstore_pkg::*;
#(
    parameter int unsigned SW          = DEF_SW,
    parameter int unsigned RESET_STATE = DEF_RESET_STATE,
    parameter int unsigned FETCH_STATE = DEF_FETCH_STATE,
    parameter int unsigned UNDEF_STATE = DEF_UNDEF_STATE,
    parameter int unsigned FAULT_STATE = DEF_FAULT_STATE,
    parameter int unsigned MOC_TIMEOUT = DEF_MOC_TIMEOUT
) (
    input logic                   clk,
    input logic                   reset,
    microstore_sequencer_if.slave bus
);
    localparam logic [SW-1:0] L_RESET = SW'(RESET_STATE);
`ifdef MOC_TIMEOUT_EN
    localparam logic [SW-1:0] L_FAULT = SW'(FAULT_STATE);
    localparam int unsigned   CW      = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
    localparam logic [CW-1:0] L_TO_LAST = CW'(MOC_TIMEOUT - 1);
`endif

    logic [SW-1:0] r_state;
    logic          r_ret_valid;
    logic [SW-1:0] r_ret_addr;
    logic          r_fault;
`ifdef MOC_TIMEOUT_EN
    logic [CW-1:0] r_to_cnt;
`endif

    logic          w_stall;
    logic [SW-1:0] w_next_state;
    logic          w_next_ret_valid;
    logic [SW-1:0] w_next_ret_addr;
    logic          w_fault_evt;

    assign w_stall   = bus.mem_op & ~bus.moc;
    assign bus.stall = w_stall;
    assign bus.state = r_state;
    assign bus.fault = r_fault;

    microstore_next_mux #(
        .SW          (SW),
        .FETCH_STATE (FETCH_STATE),
        .UNDEF_STATE (UNDEF_STATE),
        .FAULT_STATE (FAULT_STATE)
    ) u_next_mux (
        .i_ns_sel         (bus.ns_sel),
        .i_cr_addr        (bus.cr_addr),
        .i_inv            (bus.inv),
        .i_cond_true      (bus.cond_true),
        .i_enc_state      (bus.enc_state),
        .i_enc_valid      (bus.enc_valid),
        .i_state          (r_state),
        .i_ret_valid      (r_ret_valid),
        .i_ret_addr       (r_ret_addr),
        .o_next_state     (w_next_state),
        .o_next_ret_valid (w_next_ret_valid),
        .o_next_ret_addr  (w_next_ret_addr),
        .o_fault          (w_fault_evt)
    );

    // Sequencer state: reset wins, stalls hold everything, otherwise take the selected transition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= L_RESET;
            r_ret_valid <= 1'b0;
            r_ret_addr  <= '0;
            r_fault     <= 1'b0;
`ifdef MOC_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else if (w_stall) begin
`ifdef MOC_TIMEOUT_EN
            if (r_to_cnt == L_TO_LAST) begin
                r_state  <= L_FAULT;
                r_fault  <= 1'b1;
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + CW'(1);
            end
`endif
        end else begin
            r_state     <= w_next_state;
            r_ret_valid <= w_next_ret_valid;
            r_ret_addr  <= w_next_ret_addr;
            if (w_fault_evt) begin
                r_fault <= 1'b1;
            end
`ifdef MOC_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_microstore_sequencer.sv
// Directed bench for microstore_sequencer with an expected-state scoreboard.
// Build with MOC_TIMEOUT_EN defined to exercise the stall timeout.
module tb_microstore_sequencer;
    import microstore_pkg::*;

    typedef struct {
        string      tag;
        logic [7:0] st;
        logic       flt;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    microstore_sequencer_if #(.SW(8)) bus ();

    microstore_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    // Queue the expectation for the coming edge, then compare once the edge has passed
    task automatic tick(input string tag, input logic [7:0] st, input logic flt);
        exp_t e;
        sb_q.push_back('{tag: tag, st: st, flt: flt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        assert (bus.state === e.st) else begin
            n_errors++;
            $error("FAIL %s state: observed %0d expected %0d", e.tag, bus.state, e.st);
        end
        n_checks++;
        assert (bus.fault === e.flt) else begin
            n_errors++;
            $error("FAIL %s fault: observed %0b expected %0b", e.tag, bus.fault, e.flt);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        n_checks++;
        assert (bus.stall === exp) else begin
            n_errors++;
            $error("FAIL %s stall: observed %0b expected %0b", tag, bus.stall, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] cr);
        bus.ns_sel  = sel;
        bus.cr_addr = cr;
    endtask

    initial begin
        logic [7:0] to_st;
        logic       to_flt;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.ns_sel    = NS_INC;
        bus.cr_addr   = 8'd0;
        bus.inv       = 1'b0;
        bus.cond_true = 1'b0;
        bus.enc_state = 8'd0;
        bus.enc_valid = 1'b0;
        bus.mem_op    = 1'b0;
        bus.moc       = 1'b0;

        // Reset and increment
        tick("reset", 8'd0, 1'b0);
        reset = 1'b0;
        tick("inc1", 8'd1, 1'b0);
        tick("inc2", 8'd2, 1'b0);
        tick("inc3", 8'd3, 1'b0);
        drive(NS_JUMP, 8'd255);
        tick("jump255", 8'd255, 1'b0);
        drive(NS_INC, 8'd0);
        tick("inc_wrap", 8'd0, 1'b0);

        // Decode
        drive(NS_DECODE, 8'd0);
        bus.enc_valid = 1'b1;
        bus.enc_state = 8'd16;
        tick("decode", 8'd16, 1'b0);
        bus.enc_valid = 1'b0;
        tick("decode_undef", 8'd2, 1'b0);

        // Conditional branch
        drive(NS_JUMP, 8'd10);
        tick("jump10", 8'd10, 1'b0);
        drive(NS_COND, 8'd40);
        bus.cond_true = 1'b1;
        bus.inv       = 1'b0;
        tick("cond_taken", 8'd40, 1'b0);
        drive(NS_JUMP, 8'd10);
        tick("jump10b", 8'd10, 1'b0);
        drive(NS_COND, 8'd40);
        bus.inv = 1'b1;
        tick("cond_inv_nt", 8'd11, 1'b0);
        bus.cond_true = 1'b0;
        tick("cond_inv_t", 8'd40, 1'b0);
        bus.inv = 1'b0;
        tick("cond_nt", 8'd41, 1'b0);
        drive(NS_FETCH, 8'd0);
        tick("fetch", 8'd1, 1'b0);

        // Call / return / return-underflow fault, then keep sequencing while faulted
        drive(NS_JUMP, 8'd20);
        tick("jump20", 8'd20, 1'b0);
        drive(NS_CALL, 8'd50);
        tick("call50", 8'd50, 1'b0);
        drive(NS_RETURN, 8'd0);
        tick("return", 8'd21, 1'b0);
        tick("ret_underflow", 8'd255, 1'b1);
        drive(NS_INC, 8'd0);
        tick("inc_in_fault", 8'd0, 1'b1);

        // Reserved select, then call overflow keeps the return entry
        reset = 1'b1;
        drive(NS_RSVD, 8'd0);
        tick("reset2", 8'd0, 1'b0);
        reset = 1'b0;
        tick("reserved", 8'd255, 1'b1);
        reset = 1'b1;
        tick("reset3", 8'd0, 1'b0);
        reset = 1'b0;
        drive(NS_CALL, 8'd30);
        tick("call30", 8'd30, 1'b0);
        drive(NS_CALL, 8'd40);
        tick("call_overflow", 8'd255, 1'b1);
        drive(NS_RETURN, 8'd0);
        tick("ret_after_ovf", 8'd1, 1'b1);

        // MOC stall on a jump
        reset = 1'b1;
        tick("reset4", 8'd0, 1'b0);
        reset = 1'b0;
        drive(NS_JUMP, 8'd5);
        tick("jump5", 8'd5, 1'b0);
        drive(NS_JUMP, 8'd60);
        bus.mem_op = 1'b1;
        bus.moc    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_stall("stall_on", 1'b1);
            tick("stall_hold", 8'd5, 1'b0);
        end
        bus.moc = 1'b1;
        chk_stall("stall_moc", 1'b0);
        tick("stall_release", 8'd60, 1'b0);
        bus.mem_op = 1'b0;
        drive(NS_INC, 8'd0);
        chk_stall("moc_ignored", 1'b0);
        tick("inc_after_mem", 8'd61, 1'b0);

        // Stalled call holds the return register until MOC
        drive(NS_CALL, 8'd70);
        bus.mem_op = 1'b1;
        bus.moc    = 1'b0;
        tick("call_stall1", 8'd61, 1'b0);
        tick("call_stall2", 8'd61, 1'b0);
        bus.moc = 1'b1;
        tick("call_release", 8'd70, 1'b0);
        bus.mem_op = 1'b0;
        drive(NS_RETURN, 8'd0);
        tick("ret_stalled_call", 8'd62, 1'b0);

        // Long stalls: a MOC cycle restarts the count; timeout only when enabled
        reset = 1'b1;
        drive(NS_INC, 8'd0);
        tick("reset5", 8'd0, 1'b0);
        reset      = 1'b0;
        bus.mem_op = 1'b1;
        bus.moc    = 1'b0;
        for (int i = 0; i < 10; i++) tick("stall_a", 8'd0, 1'b0);
        bus.moc = 1'b1;
        tick("stall_a_rel", 8'd1, 1'b0);
        bus.moc = 1'b0;
        for (int i = 0; i < 14; i++) tick("stall_b", 8'd1, 1'b0);
`ifdef MOC_TIMEOUT_EN
        to_st  = 8'd255;
        to_flt = 1'b1;
`else
        to_st  = 8'd1;
        to_flt = 1'b0;
`endif
        tick("stall_15th", to_st, to_flt);
        for (int i = 0; i < 20; i++) tick("stall_after", to_st, to_flt);
        chk_stall("stall_before_rst", 1'b1);
        reset = 1'b1;
        tick("reset_mid_stall", 8'd0, 1'b0);
        reset      = 1'b0;
        bus.mem_op = 1'b0;
        tick("post_reset_inc", 8'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
